// File: rtl/shift_pkg.sv
// Shared definitions for the execute-stage shift unit: op encodings,
// default widths and the stage-1 payload layout.
package shift_pkg;

   localparam int DW_DEF = 16;
   localparam int SW_DEF = 4;
   localparam int RW_DEF = 3;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROL = 2'b11
   } shift_op_e;

   // Payload fields are sized by the package defaults, so the top parameters
   // are expected to stay at those defaults.
   typedef struct packed {
      shift_op_e           op;
      logic [DW_DEF-1:0]   a;
      logic [SW_DEF-1:0]   shamt;
      logic [RW_DEF-1:0]   rd;
   } s1_payload_t;

endpackage

// File: rtl/shift_core.sv
// Combinational logarithmic shifter: one level per shamt bit, largest step
// first, each level choosing zero, sign or wrap-around fill from the op.
module shift_core
   import shift_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF
) (
   input  shift_op_e       op,
   input  logic [DW-1:0]   a,
   input  logic [SW-1:0]   shamt,
   output logic [DW-1:0]   result
);

   logic [DW-1:0] stage_next;

   always_comb begin
      stage_next = a;
      for (int lvl = SW - 1; lvl >= 0; lvl--) begin
         if (shamt[lvl]) begin
            case (op)
               SH_SLL:  stage_next = stage_next << (1 << lvl);
               SH_SRL:  stage_next = stage_next >> (1 << lvl);
               SH_SRA:  stage_next = $signed(stage_next) >>> (1 << lvl);
               default: stage_next = (stage_next << (1 << lvl)) |
                                     (stage_next >> (DW - (1 << lvl)));
            endcase
         end
      end
   end

   assign result = stage_next;

endmodule

// File: rtl/shift_ex_stage.sv
// Two-stage pipelined shift unit: stage 1 latches the operands, stage 2
// latches the shifted result, destination tag and zero flag.
module shift_ex_stage
   import shift_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [DW-1:0]   in_a,
   input  logic [SW-1:0]   in_shamt,
   input  logic [RW-1:0]   in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_result,
   output logic [RW-1:0]   out_rd,
   output logic            out_zero
);

   logic            s1_valid_reg;
   s1_payload_t     s1_data_reg;
   logic            s2_valid_reg;
   logic [DW-1:0]   result_reg;
   logic [RW-1:0]   rd_reg;
   logic            zero_reg;

   logic            s2_ready;
   logic            in_fire;
   logic            s1_fire;
   logic [DW-1:0]   result_next;

   // Ready ripples back combinationally from out_ready so a full pipe can
   // still accept a new op in the same cycle the output drains.
   assign s2_ready = !s2_valid_reg | out_ready;
   assign in_ready = !s1_valid_reg | s2_ready;
   assign in_fire  = in_valid & in_ready;
   assign s1_fire  = s1_valid_reg & s2_ready;

   shift_core #(.DW(DW), .SW(SW)) u_core (
      .op     (s1_data_reg.op),
      .a      (s1_data_reg.a),
      .shamt  (s1_data_reg.shamt),
      .result (result_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         result_reg   <= '0;
         rd_reg       <= '0;
         zero_reg     <= 1'b1;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (in_fire)
            s1_valid_reg <= 1'b1;
         else if (s1_fire)
            s1_valid_reg <= 1'b0;

         if (s1_fire) begin
            s2_valid_reg <= 1'b1;
            result_reg   <= result_next;
            rd_reg       <= s1_data_reg.rd;
            zero_reg     <= (result_next == '0);
         end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
         end
      end
   end

   // Payload only loads on an accepted transfer, so idle-bus garbage never
   // reaches the shifter; a flushed entry is harmless since valid is cleared.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_data_reg.op    <= shift_op_e'(in_op);
         s1_data_reg.a     <= in_a;
         s1_data_reg.shamt <= in_shamt;
         s1_data_reg.rd    <= in_rd;
      end
   end

   assign out_valid  = s2_valid_reg;
   assign out_result = result_reg;
   assign out_rd     = rd_reg;
   assign out_zero   = zero_reg;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed and random self-checking bench for shift_ex_stage.
module tb_shift_ex_stage;
   import shift_pkg::*;

   localparam int DW = 16;
   localparam int SW = 4;
   localparam int RW = 3;
   localparam int N_RANDOM = 10000;
   localparam int RANDOM_BUDGET = 80000;

   logic            clk = 1'b0;
   logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [1:0]      in_op;
   logic [DW-1:0]   in_a, out_result;
   logic [SW-1:0]   in_shamt;
   logic [RW-1:0]   in_rd, out_rd;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   shift_ex_stage #(.DW(DW), .SW(SW), .RW(RW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_shamt   (in_shamt),
      .in_rd      (in_rd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd),
      .out_zero   (out_zero)
   );

   // Reference: straightforward behavioural shift semantics.
   function automatic logic [DW-1:0] ref_shift(input logic [1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [SW-1:0] s);
      logic [DW-1:0]   r;
      logic [DW-1:0]   ones;
      logic [2*DW-1:0] dbl;
      ones = '1;
      case (op)
         2'b00: r = a << s;
         2'b01: r = a >> s;
         2'b10: begin
            r = a >> s;
            if (a[DW-1]) r = r | ~(ones >> s);
         end
         default: begin
            dbl = {a, a} << s;
            r = dbl[2*DW-1:DW];
         end
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [SW-1:0] s, input logic [RW-1:0] rd);
      in_op = op; in_a = a; in_shamt = s; in_rd = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(2'b00, 16'h0000, 4'd0, 3'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++;
      if (out_result !== 16'h0000) begin miscompares++; $display("FAIL reset_out_result got %h want 0000", out_result); end
      vectors++;
      if (out_rd !== 3'd0) begin miscompares++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
      vectors++;
      if (out_zero !== 1'b1) begin miscompares++; $display("FAIL reset_out_zero got %b want 1", out_zero); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      $display("reset: out_valid=%b out_result=%h out_zero=%b in_ready=%b", out_valid, out_result, out_zero, in_ready);
      tick();
   endtask

   task automatic test_basic_ops();
      logic [1:0]      op_t  [2] = '{2'b00, 2'b10};
      logic [DW-1:0]   a_t   [2] = '{16'h0001, 16'h8000};
      logic [SW-1:0]   s_t   [2] = '{4'd15, 4'd4};
      logic [RW-1:0]   rd_t  [2] = '{3'd3, 3'd1};
      logic [DW-1:0]   exp_t [2] = '{16'h8000, 16'hF800};
      logic            z_t   [2] = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         drive(op_t[i], a_t[i], s_t[i], rd_t[i]);
         in_valid = 1'b1; out_ready = 1'b1;
         #1;
         vectors++;
         if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready[%0d] got %b want 1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         #1;
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid[%0d] got %b want 0", i, out_valid); end
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_result !== exp_t[i] || out_rd !== rd_t[i] || out_zero !== z_t[i]) begin
            miscompares++;
            $display("FAIL basic_result[%0d] got v=%b r=%h rd=%0d z=%b want v=1 r=%h rd=%0d z=%b",
                     i, out_valid, out_result, out_rd, out_zero, exp_t[i], rd_t[i], z_t[i]);
         end
         $display("basic op=%0d a=%h shamt=%0d -> result=%h rd=%0d zero=%b", op_t[i], a_t[i], s_t[i], out_result, out_rd, out_zero);
         tick();
      end
   endtask

   task automatic test_zero_rotate();
      logic [1:0]      op_t  [2] = '{2'b01, 2'b11};
      logic [DW-1:0]   a_t   [2] = '{16'h00F0, 16'h8001};
      logic [SW-1:0]   s_t   [2] = '{4'd8, 4'd1};
      logic [RW-1:0]   rd_t  [2] = '{3'd2, 3'd4};
      logic [DW-1:0]   exp_t [2] = '{16'h0000, 16'h0003};
      logic            z_t   [2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         drive(op_t[i], a_t[i], s_t[i], rd_t[i]);
         in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_result !== exp_t[i] || out_rd !== rd_t[i] || out_zero !== z_t[i]) begin
            miscompares++;
            $display("FAIL zero_rotate[%0d] got v=%b r=%h rd=%0d z=%b want v=1 r=%h rd=%0d z=%b",
                     i, out_valid, out_result, out_rd, out_zero, exp_t[i], rd_t[i], z_t[i]);
         end
         $display("zero_rotate op=%0d a=%h shamt=%0d -> result=%h rd=%0d zero=%b", op_t[i], a_t[i], s_t[i], out_result, out_rd, out_zero);
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]    op_t [10];
      logic [DW-1:0] a_t  [10];
      logic [SW-1:0] s_t  [10];
      logic [DW-1:0] exp_r;
      int k;
      for (int i = 0; i < 10; i++) begin
         op_t[i] = 2'(i % 4);
         a_t[i]  = 16'h9234 + 16'(i) * 16'h1111;
         s_t[i]  = 4'((i * 5) % 16);
      end
      for (int i = 0; i < 12; i++) begin
         if (i < 10) begin
            drive(op_t[i], a_t[i], s_t[i], 3'(i));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'b1;
         #1;
         if (i < 10) begin
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
         end
         vectors++;
         if (i >= 2) begin
            k = i - 2;
            exp_r = ref_shift(op_t[k], a_t[k], s_t[k]);
            if (out_valid !== 1'b1 || out_result !== exp_r || out_rd !== 3'(k) || out_zero !== (exp_r == '0)) begin
               miscompares++;
               $display("FAIL b2b_result[%0d] got v=%b r=%h rd=%0d z=%b want v=1 r=%h rd=%0d z=%b",
                        k, out_valid, out_result, out_rd, out_zero, exp_r, 3'(k), (exp_r == '0));
            end
            $display("b2b op %0d -> result=%h rd=%0d", k, out_result, out_rd);
         end else if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_early_valid[%0d] got %b want 0", i, out_valid);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] exp_a, exp_b, exp_c;
      exp_a = ref_shift(2'b00, 16'h00FF, 4'd4);
      exp_b = ref_shift(2'b11, 16'hF00F, 4'd8);
      exp_c = ref_shift(2'b10, 16'h4000, 4'd2);
      out_ready = 1'b0;
      drive(2'b00, 16'h00FF, 4'd4, 3'd1); in_valid = 1'b1;
      tick();
      drive(2'b11, 16'hF00F, 4'd8, 3'd2);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_second_accept got %b want 1", in_ready); end
      tick();
      drive(2'b10, 16'h4000, 4'd2, 3'd3);
      for (int c = 0; c < 5; c++) begin
         #1;
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== exp_a || out_rd !== 3'd1) begin
            miscompares++;
            $display("FAIL bp_hold[%0d] got rdy=%b v=%b r=%h rd=%0d want rdy=0 v=1 r=%h rd=1",
                     c, in_ready, out_valid, out_result, out_rd, exp_a);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== exp_a || out_rd !== 3'd1) begin
         miscompares++;
         $display("FAIL bp_release_a got rdy=%b v=%b r=%h rd=%0d want rdy=1 v=1 r=%h rd=1", in_ready, out_valid, out_result, out_rd, exp_a);
      end
      $display("bp deliver result=%h rd=%0d", out_result, out_rd);
      tick();
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_result !== exp_b || out_rd !== 3'd2) begin
         miscompares++;
         $display("FAIL bp_release_b got v=%b r=%h rd=%0d want v=1 r=%h rd=2", out_valid, out_result, out_rd, exp_b);
      end
      $display("bp deliver result=%h rd=%0d", out_result, out_rd);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_result !== exp_c || out_rd !== 3'd3) begin
         miscompares++;
         $display("FAIL bp_release_c got v=%b r=%h rd=%0d want v=1 r=%h rd=3", out_valid, out_result, out_rd, exp_c);
      end
      $display("bp deliver result=%h rd=%0d", out_result, out_rd);
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_duplicate got v=%b rd=%0d want v=0", out_valid, out_rd); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(2'b00, 16'h0011, 4'd1, 3'd5); in_valid = 1'b1;
      tick();
      drive(2'b01, 16'h1100, 4'd1, 3'd6);
      tick();
      drive(2'b11, 16'h1234, 4'd3, 3'd7);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      $display("flush: out_valid=%b in_ready=%b", out_valid, in_ready);
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak[%0d] got v=%b rd=%0d want v=0", c, out_valid, out_rd); end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(2'b00, 16'h0F0F, 4'd2, 3'd6); in_valid = 1'b1;
      tick();
      drive(2'b11, 16'hABCD, 4'd5, 3'd5);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_zero !== 1'b1 || out_rd !== 3'd0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid got v=%b r=%h z=%b rd=%0d rdy=%b want v=0 r=0000 z=1 rd=0 rdy=1",
                  out_valid, out_result, out_zero, out_rd, in_ready);
      end
      $display("reset_mid: out_valid=%b out_result=%h out_zero=%b", out_valid, out_result, out_zero);
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_leak[%0d] got v=%b want 0", c, out_valid); end
      end
   endtask

   task automatic test_random();
      logic [DW+RW:0] exp_q[$];
      logic [DW+RW:0] got, exp_v;
      logic [DW-1:0]  r;
      int  sent = 0;
      int  recv = 0;
      int  cycles = 0;
      bit  pending = 1'b0;
      while (recv < N_RANDOM) begin
         if (cycles >= RANDOM_BUDGET) begin
            vectors++; miscompares++;
            $display("FAIL random_timeout got %0d results want %0d", recv, N_RANDOM);
            break;
         end
         if (!pending) begin
            in_valid = (sent < N_RANDOM) && ($urandom_range(0, 3) != 0);
            in_op    = 2'($urandom_range(0, 3));
            in_a     = 16'($urandom);
            in_shamt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            in_rd    = 3'($urandom_range(0, 7));
         end
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            got = {out_result, out_rd, out_zero};
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL random_spurious got r=%h rd=%0d want no output", out_result, out_rd);
            end else begin
               exp_v = exp_q.pop_front();
               if (got !== exp_v) begin
                  miscompares++;
                  $display("FAIL random[%0d] got r=%h rd=%0d z=%b want r=%h rd=%0d z=%b", recv,
                           out_result, out_rd, out_zero, exp_v[DW+RW:RW+1], exp_v[RW:1], exp_v[0]);
               end
               $display("random %0d result=%h rd=%0d zero=%b", recv, out_result, out_rd, out_zero);
               recv++;
            end
         end
         if (in_valid && in_ready) begin
            r = ref_shift(in_op, in_a, in_shamt);
            exp_q.push_back({r, in_rd, (r == '0)});
            sent++;
            pending = 1'b0;
         end else begin
            pending = in_valid;
         end
         tick();
         cycles++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_ops();
      test_zero_rotate();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
